// File: rtl/envelope_follower.sv
// Envelope follower: recovers the amplitude envelope of a signed 16-bit sample stream.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_sample_in    signed 16-bit sample, valid when i_in_ready is high
//   i_in_ready     one-cycle sample strobe
//   o_env          smoothed envelope, 0..32767
//   o_level        envelope quantised to 0..9, updated once per STEP-sample window
//   o_level_valid  one-cycle pulse when o_level/o_phase update
//   o_phase        inferred phase: 0 attack, 1 decay, 2 sustain, 3 release
//   o_gate         hysteretic note-active flag
module envelope_follower #(
  parameter int unsigned ATTACK_SHIFT    = 2,
  parameter int unsigned RELEASE_SHIFT   = 8,
  parameter int unsigned STEP            = 480,
  parameter int unsigned GATE_ON         = 1024,
  parameter int unsigned GATE_OFF        = 512,
  parameter int unsigned SUSTAIN_WINDOWS = 3
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic signed [15:0] i_sample_in,
  input  logic               i_in_ready,
  output logic [15:0]        o_env,
  output logic [3:0]         o_level,
  output logic               o_level_valid,
  output logic [1:0]         o_phase,
  output logic               o_gate
);

  localparam int unsigned CntW  = (STEP > 1) ? $clog2(STEP) : 1;
  localparam int unsigned StabW = $clog2(SUSTAIN_WINDOWS + 1);

  typedef enum logic [1:0] {
    StAttack  = 2'd0,
    StDecay   = 2'd1,
    StSustain = 2'd2,
    StRelease = 2'd3
  } phase_e;

  phase_e             r_phase, w_phase_next;
  logic [15:0]        r_env, w_env_next;
  logic               r_gate, w_gate_next;
  logic [CntW-1:0]    r_win_cnt, w_win_cnt_next;
  logic [3:0]         r_level, w_level_next;
  logic               r_level_valid, w_level_valid_next;
  logic [StabW-1:0]   r_stable, w_stable_next;

  logic [15:0]        w_abs, w_mag, w_diff, w_step, w_env_calc;
  logic [18:0]        w_prod;
  logic [3:0]         w_lvl_raw, w_lvl;
  logic               w_win_end, w_update;
  logic [StabW-1:0]   w_stable_inc;

  // Magnitude; the most negative sample has no positive twin and saturates.
  always_comb begin
    w_abs = i_sample_in[15] ? (~i_sample_in + 16'd1) : i_sample_in;
    w_mag = w_abs[15] ? 16'd32767 : w_abs;
  end

  // Asymmetric one-pole tracker; the minimum step of 1 guarantees convergence, and since
  // the step never exceeds the error the result cannot overshoot the magnitude.
  always_comb begin
    w_diff     = 16'd0;
    w_step     = 16'd0;
    w_env_calc = r_env;
    if (w_mag > r_env) begin
      w_diff     = w_mag - r_env;
      w_step     = w_diff >> ATTACK_SHIFT;
      if (w_step == 16'd0) w_step = 16'd1;
      w_env_calc = r_env + w_step;
    end else if (w_mag < r_env) begin
      w_diff     = r_env - w_mag;
      w_step     = w_diff >> RELEASE_SHIFT;
      if (w_step == 16'd0) w_step = 16'd1;
      w_env_calc = r_env - w_step;
    end
  end

  assign w_win_end = (r_win_cnt == CntW'(STEP - 1));
  assign w_update  = i_in_ready & w_win_end;

  // env * 10 computed exactly in 19 bits, then scaled by 2^-15.
  always_comb begin
    w_prod    = ({3'b000, w_env_calc} << 3) + ({3'b000, w_env_calc} << 1);
    w_lvl_raw = 4'(w_prod >> 15);
    w_lvl     = (w_lvl_raw > 4'd9) ? 4'd9 : w_lvl_raw;
  end

  // Envelope, gate, window counter and level next-state.
  always_comb begin
    w_env_next         = r_env;
    w_gate_next        = r_gate;
    w_win_cnt_next     = r_win_cnt;
    w_level_next       = r_level;
    w_level_valid_next = 1'b0;
    if (i_in_ready) begin
      w_env_next = w_env_calc;
      if (w_env_calc >= 16'(GATE_ON)) begin
        w_gate_next = 1'b1;
      end else if (w_env_calc < 16'(GATE_OFF)) begin
        w_gate_next = 1'b0;
      end
      w_win_cnt_next = w_win_end ? '0 : r_win_cnt + CntW'(1);
      if (w_win_end) begin
        w_level_next       = w_lvl;
        w_level_valid_next = 1'b1;
      end
    end
  end

  // Phase FSM. r_level always holds the previous window's level, so it serves as P.
  assign w_stable_inc = r_stable + StabW'(1);

  always_comb begin
    w_phase_next  = r_phase;
    w_stable_next = r_stable;
    if (w_update) begin
      unique case (r_phase)
        StRelease: begin
          if (w_lvl > r_level) w_phase_next = StAttack;
        end
        StAttack: begin
          if (w_lvl < r_level) begin
            w_phase_next  = StDecay;
            w_stable_next = '0;
          end
        end
        StDecay: begin
          if (w_lvl > r_level) begin
            w_phase_next = StAttack;
          end else if (w_lvl < r_level) begin
            w_stable_next = '0;
          end else if (w_stable_inc == StabW'(SUSTAIN_WINDOWS)) begin
            w_phase_next  = StSustain;
            w_stable_next = '0;
          end else begin
            w_stable_next = w_stable_inc;
          end
        end
        StSustain: begin
          if (w_lvl < r_level) begin
            w_phase_next = StRelease;
          end else if (w_lvl > r_level) begin
            w_phase_next = StAttack;
          end
        end
        default: w_phase_next = StRelease;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_env         <= 16'd0;
      r_gate        <= 1'b0;
      r_win_cnt     <= '0;
      r_level       <= 4'd0;
      r_level_valid <= 1'b0;
      r_stable      <= '0;
      r_phase       <= StRelease;
    end else begin
      r_env         <= w_env_next;
      r_gate        <= w_gate_next;
      r_win_cnt     <= w_win_cnt_next;
      r_level       <= w_level_next;
      r_level_valid <= w_level_valid_next;
      r_stable      <= w_stable_next;
      r_phase       <= w_phase_next;
    end
  end

  assign o_env         = r_env;
  assign o_level       = r_level;
  assign o_level_valid = r_level_valid;
  assign o_phase       = r_phase;
  assign o_gate        = r_gate;

endmodule
